tdc_cfg_ser: RTL

Serial configuration transmitter driving the `rstr`/`rdata` pair of a TDC channel.
- Accepts one address/data write per valid/ready handshake.
- Shifts the write out MSB-first as a framed bit stream: `rstr` high for the whole frame, `rdata` carrying the bits.
- Sits between the slow-control register bank and each TDC channel, in the `clk300` domain.

---
 rtl/tdc_cfg_pkg.sv | 32 +++
 rtl/tdc_cfg_bitclk.sv | 43 ++++
 rtl/tdc_cfg_ser.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tdc_cfg_pkg.sv
// tdc_cfg_pkg - shared definitions for the TDC serial configuration transmitter.
//
// Contents:
//   state_e          transmitter state (IDLE, SHIFT, GAP)
//   DIV_DEFAULT      default clk300 cycles per serial bit
//   GAP_BITS_DEFAULT default idle bit periods between frames
//   frame_len()      frame length in bits for a given address/data width
//
// Build option: TDC_CFG_PARITY_EN appends one even-parity bit to every frame,
// which frame_len() accounts for.

package tdc_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int unsigned DIV_DEFAULT      = 2;
    localparam int unsigned GAP_BITS_DEFAULT = 2;

    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned data_w);
`ifdef TDC_CFG_PARITY_EN
        return addr_w + data_w + 1;
`else
        return addr_w + data_w;
`endif
    endfunction

endpackage

// File: rtl/tdc_cfg_bitclk.sv
// tdc_cfg_bitclk - bit-period divider for the configuration transmitter.
//
// Ports:
//   clk300   in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   run      in   divider enable; the count is held at zero while low
//   bit_end  out  one-cycle pulse on the last cycle of every DIV-cycle period

module tdc_cfg_bitclk
    import tdc_cfg_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk300,
    input  logic reset,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With DIV=1 the count never leaves zero, so bit_end simply follows run.
    assign bit_end = run && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = '0;
        if (run && !bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk300 or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdc_cfg_ser.sv
// tdc_cfg_ser - serial configuration transmitter for one TDC channel.
//
// Takes one address/data write per valid/ready handshake and shifts it out
// MSB-first as a framed stream: rstr is high for the whole frame and rdata
// carries the bits, each held for DIV clk300 cycles. Frames are followed by
// GAP_BITS idle bit periods with rstr low.
//
// Ports:
//   clk300    in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   wr_valid  in   write request present
//   wr_ready  out  write can be accepted (IDLE only)
//   wr_addr   in   register address, sampled at handshake
//   wr_data   in   register data, sampled at handshake
//   rstr      out  frame strobe
//   rdata     out  serial data, MSB first, 0 outside a frame
//   busy      out  high from handshake until the gap ends
//   done      out  one-cycle pulse on the first cycle after the last bit
//
// Build option: TDC_CFG_PARITY_EN appends an even-parity bit (XOR of all
// address and data bits) after the data LSB.

module tdc_cfg_ser
    import tdc_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIV      = DIV_DEFAULT,
    parameter int unsigned GAP_BITS = GAP_BITS_DEFAULT
) (
    input  logic              clk300,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rstr,
    output logic              rdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned N       = frame_len(ADDR_W, DATA_W);
    localparam int unsigned BW      = $clog2(N + 1);
    localparam int unsigned GAP_CYC = GAP_BITS * DIV;
    localparam int unsigned GW      = $clog2(GAP_CYC + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rstr_q, rstr_d;
    logic          rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          armed_q, armed_d;

    logic          run;
    logic          bit_end;
    logic          accept;
    logic [N-1:0]  payload;

`ifdef TDC_CFG_PARITY_EN
    assign payload = {wr_addr, wr_data, ^{wr_addr, wr_data}};
`else
    assign payload = {wr_addr, wr_data};
`endif

    assign run = (state_q == ST_SHIFT);

    tdc_cfg_bitclk #(
        .DIV (DIV)
    ) u_bitclk (
        .clk300  (clk300),
        .reset   (reset),
        .run     (run),
        .bit_end (bit_end)
    );

    // IDLE is the reset state, so wr_ready is additionally qualified by a
    // flop that clears with reset: this keeps wr_ready low while reset is
    // asserted and raises it on the first edge after release.
    assign wr_ready = armed_q && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        gap_d   = '0;
        done_d  = 1'b0;
        armed_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    sr_d    = payload;
                    bit_d   = BW'(N);
                end
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    sr_d  = sr_q << 1;
                    bit_d = bit_q - 1'b1;
                    if (bit_q == BW'(1)) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // state_q: rstr is high exactly for the SHIFT cycles.
        rstr_d  = (state_d == ST_SHIFT);
        rdata_d = rstr_d && sr_d[N-1];
    end

    always_ff @(posedge clk300 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            rstr_q  <= 1'b0;
            rdata_q <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rstr_q  <= rstr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign rstr  = rstr_q;
    assign rdata = rdata_q;
    assign done  = done_q;

endmodule
